// File: rtl/dct_4x4_fwd_pkg.sv
// Shared constants, widths and the round/saturate helper
// for the forward 4x4 integer DCT.
package dct_4x4_fwd_pkg;

  localparam int C64 = 64;
  localparam int C83 = 83;
  localparam int C36 = 36;

  localparam int DIN_W_DEF  = 25;
  localparam int DOUT_W_DEF = 25;
  localparam int SHIFT1_DEF = 1;
  localparam int SHIFT2_DEF = 8;
  localparam int GUARD_W    = 10;

  typedef enum logic {
    IDLE,
    DRAIN
  } drain_state_t;

  // Round half up, arithmetic shift, clamp to a w-bit signed range.
  function automatic logic signed [63:0] round_sat(
    input logic signed [63:0] y,
    input int                 s,
    input int                 w
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (y + (64'sd1 <<< (s - 1))) >>> s;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/dct_4x4_fwd_butterfly.sv
// Combinational 4-point DCT butterfly with rounding
// shift and saturation on every output.
module dct4_butterfly
  import dct_4x4_fwd_pkg::*;
#(
  parameter int IN_W  = 25,
  parameter int OUT_W = 25,
  parameter int SHIFT = 1
) (
  input  logic signed [IN_W-1:0]  x0,
  input  logic signed [IN_W-1:0]  x1,
  input  logic signed [IN_W-1:0]  x2,
  input  logic signed [IN_W-1:0]  x3,
  output logic signed [OUT_W-1:0] y0,
  output logic signed [OUT_W-1:0] y1,
  output logic signed [OUT_W-1:0] y2,
  output logic signed [OUT_W-1:0] y3
);

  localparam int AW = IN_W + GUARD_W;

  logic signed [AW-1:0] e0;
  logic signed [AW-1:0] e1;
  logic signed [AW-1:0] o0;
  logic signed [AW-1:0] o1;
  logic signed [AW-1:0] p0;
  logic signed [AW-1:0] p1;
  logic signed [AW-1:0] p2;
  logic signed [AW-1:0] p3;

  always_comb begin
    e0 = AW'(x0) + AW'(x3);
    e1 = AW'(x1) + AW'(x2);
    o0 = AW'(x0) - AW'(x3);
    o1 = AW'(x1) - AW'(x2);
    p0 = AW'(C64) * (e0 + e1);
    p2 = AW'(C64) * (e0 - e1);
    p1 = AW'(C83) * o0 + AW'(C36) * o1;
    p3 = AW'(C36) * o0 - AW'(C83) * o1;
    y0 = OUT_W'(round_sat(64'(p0), SHIFT, OUT_W));
    y1 = OUT_W'(round_sat(64'(p1), SHIFT, OUT_W));
    y2 = OUT_W'(round_sat(64'(p2), SHIFT, OUT_W));
    y3 = OUT_W'(round_sat(64'(p3), SHIFT, OUT_W));
  end

endmodule

// File: rtl/dct_4x4_fwd.sv
// Forward 4x4 DCT: row butterfly, ping-pong transpose
// buffer, column butterfly; one row in, one column out.
module dct_4x4_fwd
  import dct_4x4_fwd_pkg::*;
#(
  parameter int DIN_W  = DIN_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF,
  parameter int SHIFT1 = SHIFT1_DEF,
  parameter int SHIFT2 = SHIFT2_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DIN_W-1:0]  d_in_1,
  input  logic signed [DIN_W-1:0]  d_in_2,
  input  logic signed [DIN_W-1:0]  d_in_3,
  input  logic signed [DIN_W-1:0]  d_in_4,
  output logic                     out_valid,
  output logic                     out_last,
  output logic signed [DOUT_W-1:0] d_out_1,
  output logic signed [DOUT_W-1:0] d_out_2,
  output logic signed [DOUT_W-1:0] d_out_3,
  output logic signed [DOUT_W-1:0] d_out_4
);

  logic signed [DOUT_W-1:0] bank [2][4][4];

  logic [1:0]   row_cnt;
  logic [1:0]   col_cnt;
  logic [1:0]   col_nxt;
  logic         fill_sel;
  logic         drain_sel;
  logic         launch;
  logic         beat;
  drain_state_t state;
  drain_state_t state_nxt;

  logic signed [DOUT_W-1:0] t0, t1, t2, t3;
  logic signed [DOUT_W-1:0] c0, c1, c2, c3;
  logic signed [DOUT_W-1:0] y0, y1, y2, y3;

  dct4_butterfly #(
    .IN_W  (DIN_W),
    .OUT_W (DOUT_W),
    .SHIFT (SHIFT1)
  ) u_row (
    .x0 (d_in_1),
    .x1 (d_in_2),
    .x2 (d_in_3),
    .x3 (d_in_4),
    .y0 (t0),
    .y1 (t1),
    .y2 (t2),
    .y3 (t3)
  );

  // Column k of the drain bank is T[0..3][k].
  assign c0 = bank[drain_sel][0][col_cnt];
  assign c1 = bank[drain_sel][1][col_cnt];
  assign c2 = bank[drain_sel][2][col_cnt];
  assign c3 = bank[drain_sel][3][col_cnt];

  dct4_butterfly #(
    .IN_W  (DOUT_W),
    .OUT_W (DOUT_W),
    .SHIFT (SHIFT2)
  ) u_col (
    .x0 (c0),
    .x1 (c1),
    .x2 (c2),
    .x3 (c3),
    .y0 (y0),
    .y1 (y1),
    .y2 (y2),
    .y3 (y3)
  );

  assign launch = in_valid && (row_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (in_valid) begin
      bank[fill_sel][row_cnt][0] <= t0;
      bank[fill_sel][row_cnt][1] <= t1;
      bank[fill_sel][row_cnt][2] <= t2;
      bank[fill_sel][row_cnt][3] <= t3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_cnt   <= 2'd0;
      fill_sel  <= 1'b0;
      drain_sel <= 1'b0;
    end else if (in_valid) begin
      row_cnt <= row_cnt + 2'd1;
      if (launch) begin
        fill_sel  <= ~fill_sel;
        drain_sel <= fill_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      col_cnt <= 2'd0;
    end else begin
      state   <= state_nxt;
      col_cnt <= col_nxt;
    end
  end

  // A new block may only complete on the final drain beat.
  always_comb begin
    state_nxt = state;
    col_nxt   = col_cnt;
    beat      = 1'b0;
    unique case (state)
      IDLE: begin
        if (launch) begin
          state_nxt = DRAIN;
          col_nxt   = 2'd0;
        end
      end
      DRAIN: begin
        beat    = 1'b1;
        col_nxt = col_cnt + 2'd1;
        if (col_cnt == 2'd3 && !launch) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      d_out_1   <= '0;
      d_out_2   <= '0;
      d_out_3   <= '0;
      d_out_4   <= '0;
    end else begin
      out_valid <= beat;
      out_last  <= beat && (col_cnt == 2'd3);
      if (beat) begin
        d_out_1 <= y0;
        d_out_2 <= y1;
        d_out_3 <= y2;
        d_out_4 <= y3;
      end
    end
  end

endmodule

// File: tb/tb_dct_4x4_fwd.sv
// Self-checking bench for dct_4x4_fwd against a
// matrix-product reference model with cycle-exact beats.
module tb_dct_4x4_fwd;

  typedef struct {
    longint y[4];
    longint last;
    longint cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic signed [24:0] d_in_1 = '0;
  logic signed [24:0] d_in_2 = '0;
  logic signed [24:0] d_in_3 = '0;
  logic signed [24:0] d_in_4 = '0;
  logic out_valid;
  logic out_last;
  logic signed [24:0] d_out_1;
  logic signed [24:0] d_out_2;
  logic signed [24:0] d_out_3;
  logic signed [24:0] d_out_4;

  int n_chk = 0;
  int n_err = 0;
  longint cyc = 0;

  longint blk [4][4];
  int cm [4][4] = '{'{64, 64, 64, 64}, '{83, 36, -36, -83},
                    '{64, -64, -64, 64}, '{36, -83, 83, -36}};
  beat_t expq[$];
  beat_t b;
  longint dv [4];
  longint held [4] = '{0, 0, 0, 0};

  dct_4x4_fwd dut (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .d_in_1    (d_in_1),
    .d_in_2    (d_in_2),
    .d_in_3    (d_in_3),
    .d_in_4    (d_in_4),
    .out_valid (out_valid),
    .out_last  (out_last),
    .d_out_1   (d_out_1),
    .d_out_2   (d_out_2),
    .d_out_3   (d_out_3),
    .d_out_4   (d_out_4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint rs(input longint y, input int s);
    longint r;
    r = (y + (longint'(1) <<< (s - 1))) >>> s;
    if (r > 16777215) r = 16777215;
    if (r < -16777216) r = -16777216;
    return r;
  endfunction

  // Y = C * X^T-stage: T = rows of X times C^T, Y = C times T.
  task automatic push_expected(input longint ecyc);
    longint t [4][4];
    longint s;
    beat_t nb;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int c = 0; c < 4; c++) s += cm[j][c] * blk[r][c];
        t[r][j] = rs(s, 1);
      end
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        s = 0;
        for (int r = 0; r < 4; r++) s += cm[i][r] * t[r][k];
        nb.y[i] = rs(s, 8);
      end
      nb.last = (k == 3) ? 1 : 0;
      nb.cyc  = ecyc + k;
      expq.push_back(nb);
    end
  endtask

  always @(negedge clk) begin
    dv[0] = d_out_1;
    dv[1] = d_out_2;
    dv[2] = d_out_3;
    dv[3] = d_out_4;
    if (!rst_n) begin
      held = '{0, 0, 0, 0};
    end else if (out_valid) begin
      if (expq.size() == 0) begin
        chk("spurious_beat", expq.size(), 1);
      end else begin
        b = expq.pop_front();
        for (int i = 0; i < 4; i++) chk("d_out", dv[i], b.y[i]);
        chk("out_last", out_last, b.last);
        chk("beat_cycle", cyc, b.cyc);
        held = dv;
      end
    end else begin
      for (int i = 0; i < 4; i++) chk("hold", dv[i], held[i]);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_row(input int r);
    in_valid = 1'b1;
    d_in_1 = blk[r][0][24:0];
    d_in_2 = blk[r][1][24:0];
    d_in_3 = blk[r][2][24:0];
    d_in_4 = blk[r][3][24:0];
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic send_block(input int g0, input int g1, input int g2);
    int g [3];
    g = '{g0, g1, g2};
    for (int r = 0; r < 4; r++) begin
      send_row(r);
      if (r == 3) push_expected(cyc + 1);
      else tick(g[r]);
    end
  endtask

  task automatic fill_const(input longint v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) blk[r][c] = v;
  endtask

  task automatic fill_impulse(input longint v);
    fill_const(0);
    blk[0][0] = v;
  endtask

  function automatic longint rnd_sample(input bit wide);
    longint v;
    if (wide) begin
      v = longint'($urandom & 32'h1FF_FFFF);
      if (v >= 16777216) v -= 33554432;
    end else begin
      v = longint'($urandom_range(0, 1023)) - 512;
    end
    return v;
  endfunction

  task automatic wait_drained(input int budget);
    int n;
    n = 0;
    while (expq.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk("queue_drained", expq.size(), 0);
  endtask

  initial begin
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_dout1", d_out_1, 0);
    chk("rst_dout4", d_out_4, 0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    fill_const(16);
    send_block(0, 0, 0);
    wait_drained(20);

    fill_impulse(100);
    send_block(0, 0, 0);
    wait_drained(20);

    fill_const(16777215);
    send_block(0, 0, 0);
    wait_drained(20);

    fill_const(16);
    send_block(0, 0, 0);
    fill_impulse(100);
    send_block(0, 0, 0);
    fill_const(16);
    send_block(0, 0, 0);
    wait_drained(30);

    send_block(0, 2, 0);
    wait_drained(20);

    // Reset in the middle of a drain must kill the remaining beats.
    send_block(0, 0, 0);
    tick(1);
    rst_n = 1'b0;
    expq.delete();
    #1;
    chk("mid_drain_valid", out_valid, 0);
    chk("mid_drain_dout1", d_out_1, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    send_row(0);
    send_row(1);
    rst_n = 1'b0;
    tick(2);
    chk("mid_blk_valid", out_valid, 0);
    chk("mid_blk_dout1", d_out_1, 0);
    chk("mid_blk_dout2", d_out_2, 0);
    rst_n = 1'b1;
    tick(1);
    send_block(0, 0, 0);
    wait_drained(20);

    for (int n = 0; n < 24; n++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) blk[r][c] = rnd_sample(n % 3 == 2);
      send_block($urandom_range(0, 2) == 0 ? 1 : 0,
                 $urandom_range(0, 2) == 0 ? 2 : 0,
                 $urandom_range(0, 2) == 0 ? 1 : 0);
      tick($urandom_range(0, 2));
    end
    wait_drained(40);
    tick(2);
    chk("idle_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dct_4x4_fwd.md
Name: dct_4x4_fwd

Overview:
- Forward 4x4 integer 2-D DCT. It is the encoder-side counterpart of the IDCT_whole inverse transform.
- Accepts one 4-sample residual row per cycle and produces one 4-coefficient column per cycle, using the same 25-bit signed, 4-lane beat format the IDCT consumes.
- Structure: row transform, then a ping-pong transpose buffer, then column transform. Sustains back-to-back blocks at one row per cycle with no backpressure.

Parameters:
- DIN_W, 25, signed input sample width.
- DOUT_W, 25, signed output coefficient width; also the transpose-buffer word width.
- SHIFT1, 1, stage-1 rounding right-shift.
- SHIFT2, 8, stage-2 rounding right-shift.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- in_valid  input  1  the current d_in_1..4 row is accepted on this edge.
- d_in_1  input  DIN_W  row sample x[r][0], signed.
- d_in_2  input  DIN_W  x[r][1].
- d_in_3  input  DIN_W  x[r][2].
- d_in_4  input  DIN_W  x[r][3].
- out_valid  output  1  d_out_1..4 carry a valid coefficient column.
- out_last  output  1  high on beat 3 (final column) of a block.
- d_out_1  output  DOUT_W  Y[0][k].
- d_out_2  output  DOUT_W  Y[1][k].
- d_out_3  output  DOUT_W  Y[2][k].
- d_out_4  output  DOUT_W  Y[3][k].

Behaviour:
- Transform matrix C rows: (64,64,64,64), (83,36,-36,-83), (64,-64,-64,64), (36,-83,83,-36).
- Butterfly on input vector x:
  - e0=x0+x3, e1=x1+x2, o0=x0-x3, o1=x1-x2.
  - y0=64(e0+e1), y2=64(e0-e1), y1=83o0+36o1, y3=36o0-83o1.
- Internal arithmetic width is DIN_W+10 signed, so no intermediate overflow occurs.
- Rounding: y_out = (y + (1<<(S-1))) >>> S (arithmetic shift), then saturate to DOUT_W two's-complement range.
- Stage 1 (row transform):
  - Combinational from d_in_*.
  - Result T[r][0..3] is written into the fill bank at row row_cnt on each edge with in_valid=1.
  - row_cnt (2 bits) increments per accepted row and wraps 3->0.
  - When row 3 is written, the fill bank is marked full, the bank select toggles, and a drain of that bank is launched.
- in_valid=0 cycles: no write and no count change. Gaps are allowed anywhere inside a block.
- Stage 2 (column transform):
  - Drain FSM states: IDLE, DRAIN.
  - In DRAIN, col_cnt 0..3 reads column k=col_cnt of the drain bank and registers the column butterfly (SHIFT2) into d_out_*.
  - Sets out_valid=1 each beat and out_last=(col_cnt==3).
  - After col_cnt 3 it returns to IDLE, or stays in DRAIN with col_cnt=0 if another bank became full on that same edge.
- Latency: the edge that accepts row 3 is E. Beat k is visible after edge E+1+k, so out_valid is high for exactly 4 consecutive cycles.
- Ping-pong guarantee:
  - A fill takes at least 4 edges and a drain exactly 4, so the drain always completes before the other bank's drain is needed.
  - No overrun is possible and there is no ready signal.
- Outputs hold their last value when out_valid=0.
- Reset (any time, including mid-block or mid-drain): all of the following are cleared.
  - row_cnt=0, col_cnt=0, bank select=0, FSM=IDLE.
  - out_valid=0, out_last=0, d_out_1..4=0.
  - Any partial block is discarded.
  - Buffer contents are not reset.

Decomposition:
- Shared package holds the coefficient constants (C64=64, C83=83, C36=36), the default widths and shifts, and a saturate/round function.
- One sub-module, dct4_butterfly (parameters IN_W, OUT_W, SHIFT; purely combinational), is instantiated twice: stage 1 with SHIFT1, stage 2 with SHIFT2.

Test Plan:
- Flat block: 4 rows of (16,16,16,16) on consecutive cycles.
  - Beat 0 = (2048,0,0,0); beats 1-3 = (0,0,0,0).
  - out_valid high for 4 cycles starting 2 edges after row 3; out_last on beat 3.
- Impulse: row 0 = (100,0,0,0), rows 1-3 = 0.
  - Beat 0 = (800,1038,800,450).
- Saturation: all 16 samples = 16777215.
  - Beat 0 = (16777215,0,0,0); remaining coefficients 0; no wrap to negative.
- Back-to-back: 3 blocks (flat, impulse, flat) with in_valid held high for 12 cycles.
  - 12 consecutive valid beats, correct per block, no gap or corruption.
- Gapped input: same flat block with in_valid low for 2 cycles between rows 1 and 2.
  - Identical outputs, shifted by 2 cycles.
- Reset mid-block: assert reset after 2 rows, release, then send one full flat block.
  - Outputs are 0 and out_valid=0 during reset.
  - Exactly 4 beats follow, matching the flat result; no stale rows appear.
